irda_fir_rx_ctrl: RTL and testbench
===================================

// Module: irda_fir_rx_ctrl
//
// PURPOSE
// Sequencer for the FIR receive path. Issues fir_rx_restart and watches the receiver's end-of-frame and error outputs.
// Supervises each frame with an inactivity timeout and records one status entry per frame (length, CRC error,
// rx error, timeout) in a small status FIFO. Software reads that FIFO; the controller then re-arms the receiver.
//
// PARAMETERS
// STAT_AW        2      log2 of status FIFO depth (depth 4)
// TIMEOUT_TICKS  1024   rx4 ticks with no rxfifo_add_i in RECV before the frame is aborted; width 11 bits
//
// PORTS
// clk               in   1   system clock
// wb_rst_i          in   1   asynchronous, active-high reset
// rx_enable_i       in   1   software FIR receive enable
// fast_enable       in   1   FIR mode selected; low is treated as disabled
// fir_rx4_enable    in   1   4 MHz chip-rate tick (1-clk strobe)
// fir_ifdlr_i       in   16  receiver byte count of the current frame
// crc32_error_i     in   1   receiver CRC verdict
// fir_sto_detected_i in  1   receiver stop flag (delayed)
// fir_rx_error_i    in   1   receiver bad chip / break
// rxfifo_add_i      in   1   receiver pushed a data word (activity)
// fir_rx_restart_o  out  1   restart to receiver
// stat_rd_i         in   1   pop one status entry (1 clk)
// stat_dat_o        out  19  head entry {timeout,rx_err,crc_err,len[15:0]}
// stat_empty_o      out  1   status FIFO empty
// stat_full_o       out  1   status FIFO full
// frame_int_o       out  1   level interrupt = !stat_empty_o
// overrun_o         out  1   sticky: an entry was dropped
// ovr_clr_i         in   1   clears overrun_o
//
// BEHAVIOUR
// Reset values: fir_rx_restart_o=1, stat_dat_o=0, stat_empty_o=1, stat_full_o=0, frame_int_o=0, overrun_o=0.
// State at reset: IDLE. FIFO pointers at reset: 0.
// en = rx_enable_i & fast_enable. When en is low in any state: go to IDLE next clk. No status entry is written.
// FSM. Transitions on clk unless marked [tick], which means qualified by fir_rx4_enable.
//  IDLE:    fir_rx_restart_o=1. If en, go to RESTART.
//  RESTART: fir_rx_restart_o=1 for exactly this one clk. Then go to ARMED.
//  ARMED:   restart=0. [tick] on fir_rx_error_i: go to RESTART, no entry.
//           On rxfifo_add_i or fir_ifdlr_i!=0: go to RECV. Load the timeout counter with TIMEOUT_TICKS-1.
//  RECV:    [tick] timeout counter decrements. rxfifo_add_i reloads it.
//           Priority order:
//             1. fir_rx_error_i: push {0,1,0,len}.
//             2. fir_sto_detected_i: go to STATUS.
//             3. counter==0: push {1,0,0,len}.
//           After a push in case 1 or 3: go to RESTART.
//  STATUS:  push {0,0,crc32_error_i,fir_ifdlr_i} (CRC is already valid 2 ticks after stop). Then go to RESTART.
// len is fir_ifdlr_i sampled in the same clk as the push.
// Status FIFO: synchronous. stat_dat_o shows the head entry with zero latency (0 when empty).
//  Read when empty: ignored.
//  Push when full and no read in the same clk: entry dropped and overrun_o set. overrun_o stays set until ovr_clr_i.
//  Push and read in the same clk when full: both happen, no overrun.
//  Push and read in the same clk when empty: the pushed entry stays, empty_o deasserts.
//  ovr_clr_i and an overrun in the same clk: set wins.
// Pointers are STAT_AW+1 bits and wrap modulo 2*depth. full and empty are derived from the MSB compare.
// Status FIFO latency: push at clk n gives stat_empty_o=0 and frame_int_o=1 at n+1.
// Minimum gap between frames: one restart clk. Stop/error events during RESTART are ignored.
//
// STRUCTURE
// Constants go in irda_defines.v: FSM state codes (3-bit), status bit positions (`FIR_ST_TO=18, `FIR_ST_RXE=17,
// `FIR_ST_CRC=16), and the status width 19.
// One sub-module: irda_fir_stat_fifo (parameterised width/depth register FIFO, with overrun flag).
// The FSM and the timeout counter live in the top level.
//
// TESTING
// 1. rx_enable 0->1: restart held high, then one extra RESTART clk, then 0.
//    rxfifo_add then sto with crc32_error_i=0 and ifdlr=0x0040: one entry 0x00040, int=1.
// 2. Same frame but crc32_error_i=1: entry 0x10040, then the receiver is restarted.
// 3. In RECV, fir_rx_error_i and sto in the same tick: entry 0x2xxxx only (error wins), no STATUS entry.
// 4. TIMEOUT_TICKS=8 with no rxfifo_add after the first: timeout on the 8th tick, entry 0x4xxxx.
// 5. Five frames with no reads: full after 4 entries, 5th dropped, overrun=1.
//    Read+push in the same clk when full gives no overrun. ovr_clr clears the flag.
// 6. rx_enable dropped mid-RECV: IDLE next clk, restart=1, no entry. Reset mid-frame: all outputs at reset values.

Source files
------------

// File: rtl/irda_fir_rx_ctrl_pkg.sv
// Shared definitions for the FIR receive controller: FSM state codes,
// status-word bit positions and a helper that packs a status entry.
package irda_fir_rx_ctrl_pkg;

    localparam int FIR_STAT_W = 19;
    localparam int FIR_ST_TO  = 18;
    localparam int FIR_ST_RXE = 17;
    localparam int FIR_ST_CRC = 16;

    typedef enum logic [2:0] {
        FIR_IDLE    = 3'd0,
        FIR_RESTART = 3'd1,
        FIR_ARMED   = 3'd2,
        FIR_RECV    = 3'd3,
        FIR_STATUS  = 3'd4
    } fir_rx_state_e;

    // Pack one status entry {timeout, rx_err, crc_err, len[15:0]}.
    function automatic logic [FIR_STAT_W-1:0] fir_stat_word(input logic        to,
                                                            input logic        rxe,
                                                            input logic        crc,
                                                            input logic [15:0] len);
        logic [FIR_STAT_W-1:0] w;
        w             = '0;
        w[FIR_ST_TO]  = to;
        w[FIR_ST_RXE] = rxe;
        w[FIR_ST_CRC] = crc;
        w[15:0]       = len;
        return w;
    endfunction

endpackage

// File: rtl/irda_fir_rx_ctrl_stat_fifo.sv
// Small register FIFO for per-frame status entries. Head entry is visible
// with zero latency (zero when empty); a push into a full FIFO without a
// simultaneous read is dropped and raises a sticky overrun flag.
module irda_fir_rx_ctrl_stat_fifo #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              pop,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] rd_dat,
    output logic              empty,
    output logic              full,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_pop;
    logic              do_push;
    logic              ovr_set;

    // Flags from the extra pointer MSB; a read frees a slot for a same-clk push.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        ovr_set = push && full && !do_pop;
        rd_dat  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    end

    // Pointer and overrun bookkeeping; a new overrun beats a clear.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    // Entry storage; contents are only observed through the empty-gated head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/irda_fir_rx_ctrl.sv
// FIR receive sequencer: restarts the receiver, supervises each frame with an
// rx4-tick inactivity timeout and logs one status entry per frame into the
// status FIFO that software drains.
module irda_fir_rx_ctrl
    import irda_fir_rx_ctrl_pkg::*;
#(
    parameter int STAT_AW       = 2,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  rx_enable_i,
    input  logic                  fast_enable,
    input  logic                  fir_rx4_enable,
    input  logic [15:0]           fir_ifdlr_i,
    input  logic                  crc32_error_i,
    input  logic                  fir_sto_detected_i,
    input  logic                  fir_rx_error_i,
    input  logic                  rxfifo_add_i,
    output logic                  fir_rx_restart_o,
    input  logic                  stat_rd_i,
    output logic [FIR_STAT_W-1:0] stat_dat_o,
    output logic                  stat_empty_o,
    output logic                  stat_full_o,
    output logic                  frame_int_o,
    output logic                  overrun_o,
    input  logic                  ovr_clr_i
);

    localparam int              TO_W    = $clog2(TIMEOUT_TICKS) + 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_TICKS - 1);

    fir_rx_state_e         state;
    logic [TO_W-1:0]       to_cnt;
    logic                  en;
    logic                  push_err;
    logic                  push_to;
    logic                  push_st;
    logic                  push;
    logic [FIR_STAT_W-1:0] push_dat;

    assign en          = rx_enable_i & fast_enable;
    assign frame_int_o = !stat_empty_o;

    // Decide this clk's status push; rx error outranks stop, stop outranks timeout.
    always_comb begin
        push_err = 1'b0;
        push_to  = 1'b0;
        push_st  = 1'b0;
        if (en) begin
            push_err = (state == FIR_RECV) && fir_rx_error_i;
            push_to  = (state == FIR_RECV) && !fir_rx_error_i && !fir_sto_detected_i &&
                       fir_rx4_enable && (to_cnt == '0);
            push_st  = (state == FIR_STATUS);
        end
        push     = push_err | push_to | push_st;
        push_dat = fir_stat_word(push_to, push_err, push_st & crc32_error_i, fir_ifdlr_i);
    end

    // Frame sequencer with registered restart and the inactivity counter.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state            <= FIR_IDLE;
            fir_rx_restart_o <= 1'b1;
            to_cnt           <= '0;
        end else if (!en) begin
            state            <= FIR_IDLE;
            fir_rx_restart_o <= 1'b1;
        end else begin
            case (state)
                FIR_IDLE: begin
                    state            <= FIR_RESTART;
                    fir_rx_restart_o <= 1'b1;
                end
                FIR_RESTART: begin
                    state            <= FIR_ARMED;
                    fir_rx_restart_o <= 1'b0;
                end
                FIR_ARMED: begin
                    if (fir_rx4_enable && fir_rx_error_i) begin
                        state            <= FIR_RESTART;
                        fir_rx_restart_o <= 1'b1;
                    end else if (rxfifo_add_i || (fir_ifdlr_i != '0)) begin
                        state  <= FIR_RECV;
                        to_cnt <= TO_LOAD;
                    end
                end
                FIR_RECV: begin
                    if (push_err || push_to) begin
                        state            <= FIR_RESTART;
                        fir_rx_restart_o <= 1'b1;
                    end else if (fir_sto_detected_i) begin
                        state <= FIR_STATUS;
                    end
                    if (rxfifo_add_i)
                        to_cnt <= TO_LOAD;
                    else if (fir_rx4_enable && (to_cnt != '0))
                        to_cnt <= to_cnt - TO_W'(1);
                end
                FIR_STATUS: begin
                    state            <= FIR_RESTART;
                    fir_rx_restart_o <= 1'b1;
                end
                default: begin
                    state            <= FIR_IDLE;
                    fir_rx_restart_o <= 1'b1;
                end
            endcase
        end
    end

    irda_fir_rx_ctrl_stat_fifo #(
        .DATA_W (FIR_STAT_W),
        .ADDR_W (STAT_AW)
    ) u_stat_fifo (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .push     (push),
        .wr_dat   (push_dat),
        .pop      (stat_rd_i),
        .ovr_clr  (ovr_clr_i),
        .rd_dat   (stat_dat_o),
        .empty    (stat_empty_o),
        .full     (stat_full_o),
        .overrun  (overrun_o)
    );

endmodule

// File: tb/tb_irda_fir_rx_ctrl.sv
// Bench for irda_fir_rx_ctrl: directed frame scenarios followed by random
// traffic, all compared every clk against a queue-based reference model.
module tb_irda_fir_rx_ctrl;

    localparam int T     = 8;
    localparam int DEPTH = 4;

    localparam int P_IDLE = 0;
    localparam int P_RST  = 1;
    localparam int P_ARM  = 2;
    localparam int P_RECV = 3;
    localparam int P_STAT = 4;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        rx_enable_i;
    logic        fast_enable;
    logic        fir_rx4_enable;
    logic [15:0] fir_ifdlr_i;
    logic        crc32_error_i;
    logic        fir_sto_detected_i;
    logic        fir_rx_error_i;
    logic        rxfifo_add_i;
    logic        fir_rx_restart_o;
    logic        stat_rd_i;
    logic [18:0] stat_dat_o;
    logic        stat_empty_o;
    logic        stat_full_o;
    logic        frame_int_o;
    logic        overrun_o;
    logic        ovr_clr_i;

    always #5 clk = ~clk;

    irda_fir_rx_ctrl #(.STAT_AW(2), .TIMEOUT_TICKS(T)) dut (
        .clk                (clk),
        .wb_rst_i           (wb_rst_i),
        .rx_enable_i        (rx_enable_i),
        .fast_enable        (fast_enable),
        .fir_rx4_enable     (fir_rx4_enable),
        .fir_ifdlr_i        (fir_ifdlr_i),
        .crc32_error_i      (crc32_error_i),
        .fir_sto_detected_i (fir_sto_detected_i),
        .fir_rx_error_i     (fir_rx_error_i),
        .rxfifo_add_i       (rxfifo_add_i),
        .fir_rx_restart_o   (fir_rx_restart_o),
        .stat_rd_i          (stat_rd_i),
        .stat_dat_o         (stat_dat_o),
        .stat_empty_o       (stat_empty_o),
        .stat_full_o        (stat_full_o),
        .frame_int_o        (frame_int_o),
        .overrun_o          (overrun_o),
        .ovr_clr_i          (ovr_clr_i)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: controller phase, ticks since last activity, status queue.
    int          m_phase;
    int          m_idle;
    logic [18:0] m_q[$];
    logic        m_ovr;
    logic        m_restart;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [18:0] entry(input int to, input int rxe, input int crc, input int len);
        return 19'(to * 262144 + rxe * 131072 + crc * 65536 + len);
    endfunction

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_idle    = 0;
        m_q.delete();
        m_ovr     = 1'b0;
        m_restart = 1'b1;
    endtask

    // Apply one clk of the controller rules to the model using the current inputs.
    task automatic model_edge();
        int          nxt;
        int          pre;
        logic        do_push;
        logic        ovr_set;
        logic [18:0] pv;
        nxt     = m_phase;
        do_push = 1'b0;
        ovr_set = 1'b0;
        pv      = '0;
        if (!(rx_enable_i && fast_enable)) begin
            nxt = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: nxt = P_RST;
                P_RST:  nxt = P_ARM;
                P_ARM: begin
                    if (fir_rx4_enable && fir_rx_error_i) nxt = P_RST;
                    else if (rxfifo_add_i || fir_ifdlr_i != 16'd0) begin
                        nxt    = P_RECV;
                        m_idle = 0;
                    end
                end
                P_RECV: begin
                    if (fir_rx_error_i) begin
                        do_push = 1'b1;
                        pv      = entry(0, 1, 0, int'(fir_ifdlr_i));
                        nxt     = P_RST;
                    end else if (fir_sto_detected_i) begin
                        nxt = P_STAT;
                    end else if (fir_rx4_enable && m_idle == T - 1) begin
                        do_push = 1'b1;
                        pv      = entry(1, 0, 0, int'(fir_ifdlr_i));
                        nxt     = P_RST;
                    end
                    if (rxfifo_add_i) m_idle = 0;
                    else if (fir_rx4_enable) m_idle++;
                end
                P_STAT: begin
                    do_push = 1'b1;
                    pv      = entry(0, 0, int'(crc32_error_i), int'(fir_ifdlr_i));
                    nxt     = P_RST;
                end
                default: ;
            endcase
        end
        pre = m_q.size();
        if (stat_rd_i && pre > 0) void'(m_q.pop_front());
        if (do_push) begin
            if (pre < DEPTH || stat_rd_i) m_q.push_back(pv);
            else ovr_set = 1'b1;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (ovr_clr_i) m_ovr = 1'b0;
        m_phase   = nxt;
        m_restart = (nxt == P_IDLE || nxt == P_RST);
    endtask

    task automatic compare_all();
        logic [18:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 19'd0;
        chk("restart", 32'(fir_rx_restart_o), 32'(m_restart));
        chk("stat_dat", 32'(stat_dat_o), 32'(head));
        chk("empty", 32'(stat_empty_o), 32'(m_q.size() == 0));
        chk("full", 32'(stat_full_o), 32'(m_q.size() == DEPTH));
        chk("frame_int", 32'(frame_int_o), 32'(m_q.size() != 0));
        chk("overrun", 32'(overrun_o), 32'(m_ovr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_pulses();
        fir_rx4_enable     = 1'b0;
        rxfifo_add_i       = 1'b0;
        fir_sto_detected_i = 1'b0;
        fir_rx_error_i     = 1'b0;
        stat_rd_i          = 1'b0;
        ovr_clr_i          = 1'b0;
        crc32_error_i      = 1'b0;
        fir_ifdlr_i        = 16'd0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        #1;
        model_reset();
        chk("rst_restart", 32'(fir_rx_restart_o), 32'd1);
        chk("rst_dat", 32'(stat_dat_o), 32'd0);
        chk("rst_empty", 32'(stat_empty_o), 32'd1);
        chk("rst_full", 32'(stat_full_o), 32'd0);
        chk("rst_int", 32'(frame_int_o), 32'd0);
        chk("rst_ovr", 32'(overrun_o), 32'd0);
        @(negedge clk);
        wb_rst_i = 1'b0;
    endtask

    // One good frame starting and ending in ARMED; optional read/clear on the push clk.
    task automatic run_frame(input logic crc, input logic [15:0] len,
                             input logic rd_at, input logic clr_at);
        rxfifo_add_i = 1'b1;
        step();
        rxfifo_add_i       = 1'b0;
        fir_ifdlr_i        = len;
        crc32_error_i      = crc;
        fir_sto_detected_i = 1'b1;
        step();
        fir_sto_detected_i = 1'b0;
        stat_rd_i          = rd_at;
        ovr_clr_i          = clr_at;
        step();
        chk("frame_restart", 32'(fir_rx_restart_o), 32'd1);
        stat_rd_i     = 1'b0;
        ovr_clr_i     = 1'b0;
        fir_ifdlr_i   = 16'd0;
        crc32_error_i = 1'b0;
        step();
    endtask

    task automatic drain();
        while (m_q.size() > 0) begin
            stat_rd_i = 1'b1;
            step();
        end
        stat_rd_i = 1'b0;
    endtask

    initial begin
        wb_rst_i    = 1'b0;
        rx_enable_i = 1'b0;
        fast_enable = 1'b0;
        clear_pulses();
        model_reset();
        #2;
        do_reset();

        // Enable: restart stays high through IDLE and one RESTART clk, then drops.
        step();
        rx_enable_i = 1'b1;
        fast_enable = 1'b1;
        step();
        chk("t1_restart_hi", 32'(fir_rx_restart_o), 32'd1);
        step();
        chk("t1_restart_lo", 32'(fir_rx_restart_o), 32'd0);
        run_frame(1'b0, 16'h0040, 1'b0, 1'b0);
        chk("t1_entry", 32'(stat_dat_o), 32'h00040);
        chk("t1_int", 32'(frame_int_o), 32'd1);
        drain();

        // CRC error frame.
        run_frame(1'b1, 16'h0040, 1'b0, 1'b0);
        chk("t2_entry", 32'(stat_dat_o), 32'h10040);
        drain();

        // Error and stop together: only the error entry.
        rxfifo_add_i = 1'b1;
        step();
        rxfifo_add_i       = 1'b0;
        fir_ifdlr_i        = 16'h0123;
        fir_rx_error_i     = 1'b1;
        fir_sto_detected_i = 1'b1;
        fir_rx4_enable     = 1'b1;
        step();
        clear_pulses();
        chk("t3_entry", 32'(stat_dat_o), 32'h20123);
        step();
        step();
        stat_rd_i = 1'b1;
        step();
        stat_rd_i = 1'b0;
        chk("t3_single", 32'(stat_empty_o), 32'd1);

        // Inactivity timeout on the T-th tick.
        rxfifo_add_i = 1'b1;
        step();
        rxfifo_add_i = 1'b0;
        fir_ifdlr_i  = 16'h0012;
        for (int i = 1; i <= T; i++) begin
            fir_rx4_enable = 1'b1;
            step();
            fir_rx4_enable = 1'b0;
            if (i < T) begin
                chk("t4_wait", 32'(stat_empty_o), 32'd1);
                step();
            end
        end
        chk("t4_entry", 32'(stat_dat_o), 32'h40012);
        fir_ifdlr_i = 16'd0;
        step();
        step();
        drain();

        // Fill, overflow, read+push when full, clear vs. set.
        for (int k = 0; k < 5; k++) begin
            run_frame(1'b0, 16'(k + 1), 1'b0, 1'b0);
            if (k == 3) begin
                chk("t5_full", 32'(stat_full_o), 32'd1);
                chk("t5_no_ovr", 32'(overrun_o), 32'd0);
            end
        end
        chk("t5_ovr", 32'(overrun_o), 32'd1);
        chk("t5_head", 32'(stat_dat_o), 32'h00001);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("t5_clr", 32'(overrun_o), 32'd0);
        run_frame(1'b0, 16'h00AA, 1'b1, 1'b0);
        chk("t5_rdpush_ovr", 32'(overrun_o), 32'd0);
        chk("t5_rdpush_full", 32'(stat_full_o), 32'd1);
        chk("t5_rdpush_head", 32'(stat_dat_o), 32'h00002);
        run_frame(1'b0, 16'h00BB, 1'b0, 1'b1);
        chk("t5_set_wins", 32'(overrun_o), 32'd1);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        drain();

        // Enable dropped mid-frame, then reset mid-frame.
        rxfifo_add_i = 1'b1;
        step();
        rxfifo_add_i = 1'b0;
        rx_enable_i  = 1'b0;
        step();
        chk("t6_restart", 32'(fir_rx_restart_o), 32'd1);
        chk("t6_no_entry", 32'(stat_empty_o), 32'd1);
        rx_enable_i = 1'b1;
        step();
        step();
        run_frame(1'b0, 16'h0077, 1'b0, 1'b0);
        rxfifo_add_i = 1'b1;
        step();
        rxfifo_add_i = 1'b0;
        do_reset();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rx_enable_i        = ($urandom_range(0, 99) < 97);
            fast_enable        = ($urandom_range(0, 99) < 98);
            fir_rx4_enable     = ($urandom_range(0, 2) == 0);
            rxfifo_add_i       = ($urandom_range(0, 99) < 8);
            fir_sto_detected_i = ($urandom_range(0, 99) < 4);
            fir_rx_error_i     = ($urandom_range(0, 99) < 3);
            crc32_error_i      = 1'($urandom_range(0, 1));
            fir_ifdlr_i        = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
            stat_rd_i          = ($urandom_range(0, 99) < 15);
            ovr_clr_i          = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
